// File: rtl/lsu_ctrl.sv
// lsu_ctrl: handshaked load/store unit between execute and data memory.
// Steers store data to byte lanes, extends load data, flags bad accesses and response timeouts.
module lsu_ctrl #(
   parameter int AWIDTH  = 32,
   parameter int DWIDTH  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                is_store_i,
   input  logic [2:0]          funct3_i,
   input  logic [AWIDTH-1:0]   addr_i,
   input  logic [DWIDTH-1:0]   wdata_i,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [AWIDTH-1:0]   mem_addr_o,
   output logic [DWIDTH-1:0]   mem_wdata_o,
   output logic [DWIDTH/8-1:0] mem_wstrb_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [DWIDTH-1:0]   mem_rdata_i,
   output logic                resp_valid_o,
   output logic [DWIDTH-1:0]   resp_data_o,
   output logic [1:0]          resp_err_o
);
   localparam int NB = DWIDTH / 8;
   localparam int OB = $clog2(NB);
   localparam bit D64 = (DWIDTH == 64);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t            r_state, w_next;
   logic              r_store, r_mem_req;
   logic [2:0]        r_f3;
   logic [AWIDTH-1:0] r_addr;
   logic [DWIDTH-1:0] r_wdata, r_data;
   logic [7:0]        r_cnt;
   logic [1:0]        r_err;
   logic              w_accept, w_legal, w_mis, w_sign;
   logic [OB-1:0]     w_off;
   logic [NB-1:0]     w_bmask;
   logic [DWIDTH-1:0] w_dmask, w_shift, w_load;

   assign w_accept = req_valid_i && req_ready_o;
   assign w_legal  = is_store_i ? (!funct3_i[2] && (funct3_i[1:0] != 2'd3 || D64))
                   : (funct3_i == 3'd7) ? 1'b0
                   : (funct3_i == 3'd3 || funct3_i == 3'd6) ? D64 : 1'b1;
   assign w_mis    = (funct3_i[1:0] == 2'd1 && addr_i[0])
                  || (funct3_i[1:0] == 2'd2 && addr_i[1:0] != 2'd0)
                  || (funct3_i[1:0] == 2'd3 && addr_i[2:0] != 3'd0);

   // byte mask of the access size, right-aligned; shifted by the lane offset for strobes
   assign w_off   = r_addr[OB-1:0];
   assign w_bmask = NB'(r_f3[1:0] == 2'd0 ? 8'h01 : r_f3[1:0] == 2'd1 ? 8'h03 :
                        r_f3[1:0] == 2'd2 ? 8'h0F : 8'hFF);

   for (genvar i = 0; i < NB; i++) begin : g_mask
      assign w_dmask[8*i +: 8] = {8{w_bmask[i]}};
   end

   assign w_shift = mem_rdata_i >> {w_off, 3'b000};
   assign w_sign  = !r_f3[2] && (r_f3[1:0] == 2'd0 ? w_shift[7] :
                                 r_f3[1:0] == 2'd1 ? w_shift[15] : w_shift[31]);
   assign w_load  = (w_shift & w_dmask) | ({DWIDTH{w_sign}} & ~w_dmask);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (req_valid_i) w_next = (!w_legal || w_mis) ? RESP : REQ;
         REQ:     if (mem_gnt_i) w_next = r_store ? RESP : WAIT;
         WAIT:    if (mem_rvalid_i || r_cnt == 8'(TIMEOUT - 1)) w_next = RESP;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_store   <= 1'b0;
         r_f3      <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_mem_req <= 1'b0;
         r_cnt     <= '0;
         r_err     <= '0;
         r_data    <= '0;
      end else begin
         r_state   <= w_next;
         r_mem_req <= (w_next == REQ);
         r_cnt     <= (r_state == WAIT) ? r_cnt + 8'd1 : 8'd0;
         if (w_accept) begin
            r_store <= is_store_i;
            r_f3    <= funct3_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_err   <= !w_legal ? 2'd2 : w_mis ? 2'd1 : 2'd0;
            r_data  <= '0;
         end
         // data wins over timeout when both land in the same cycle
         if (r_state == WAIT) begin
            r_err  <= mem_rvalid_i ? 2'd0 : 2'd3;
            r_data <= mem_rvalid_i ? w_load : '0;
         end
      end
   end

   assign req_ready_o  = (r_state == IDLE);
   assign mem_req_o    = r_mem_req;
   assign mem_we_o     = r_mem_req && r_store;
   assign mem_addr_o   = r_mem_req ? {r_addr[AWIDTH-1:OB], OB'(0)} : '0;
   assign mem_wdata_o  = r_mem_req ? (r_wdata & w_dmask) << {w_off, 3'b000} : '0;
   assign mem_wstrb_o  = r_mem_req ? w_bmask << w_off : '0;
   assign resp_valid_o = (r_state == RESP);
   assign resp_data_o  = resp_valid_o ? r_data : '0;
   assign resp_err_o   = resp_valid_o ? r_err : '0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized bench for lsu_ctrl at DWIDTH 32 and 64 against a transaction-level model.
module tb_lsu_ctrl;
   localparam int TMO32 = 4;
   localparam int TMO64 = 6;

   logic        clk = 1'b0, rst = 1'b0;
   logic        rv32 = 1'b0, rv64 = 1'b0, st = 1'b0, gnt = 1'b0, rvalid = 1'b0, sel = 1'b0;
   logic [2:0]  f3 = '0;
   logic [31:0] addr = '0;
   logic [63:0] wdata = '0, rdata = '0;

   logic        a_rdy, a_req, a_we, a_rv;
   logic [31:0] a_addr, a_wd, a_rd;
   logic [3:0]  a_strb;
   logic [1:0]  a_err;
   logic        b_rdy, b_req, b_we, b_rv;
   logic [31:0] b_addr;
   logic [63:0] b_wd, b_rd;
   logic [7:0]  b_strb;
   logic [1:0]  b_err;

   logic        m_rdy, m_req, m_we, m_rv;
   logic [31:0] m_addr;
   logic [63:0] m_wd, m_rd;
   logic [7:0]  m_strb;
   logic [1:0]  m_err;

   int n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   lsu_ctrl #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(TMO32)) u32 (
      .clk(clk), .rst(rst), .req_valid_i(rv32), .req_ready_o(a_rdy), .is_store_i(st),
      .funct3_i(f3), .addr_i(addr), .wdata_i(wdata[31:0]), .mem_req_o(a_req), .mem_we_o(a_we),
      .mem_addr_o(a_addr), .mem_wdata_o(a_wd), .mem_wstrb_o(a_strb), .mem_gnt_i(gnt),
      .mem_rvalid_i(rvalid), .mem_rdata_i(rdata[31:0]), .resp_valid_o(a_rv),
      .resp_data_o(a_rd), .resp_err_o(a_err));

   lsu_ctrl #(.AWIDTH(32), .DWIDTH(64), .TIMEOUT(TMO64)) u64 (
      .clk(clk), .rst(rst), .req_valid_i(rv64), .req_ready_o(b_rdy), .is_store_i(st),
      .funct3_i(f3), .addr_i(addr), .wdata_i(wdata), .mem_req_o(b_req), .mem_we_o(b_we),
      .mem_addr_o(b_addr), .mem_wdata_o(b_wd), .mem_wstrb_o(b_strb), .mem_gnt_i(gnt),
      .mem_rvalid_i(rvalid), .mem_rdata_i(rdata), .resp_valid_o(b_rv),
      .resp_data_o(b_rd), .resp_err_o(b_err));

   assign m_rdy  = sel ? b_rdy  : a_rdy;
   assign m_req  = sel ? b_req  : a_req;
   assign m_we   = sel ? b_we   : a_we;
   assign m_rv   = sel ? b_rv   : a_rv;
   assign m_addr = sel ? b_addr : a_addr;
   assign m_wd   = sel ? b_wd   : {32'd0, a_wd};
   assign m_strb = sel ? b_strb : {4'd0, a_strb};
   assign m_rd   = sel ? b_rd   : {32'd0, a_rd};
   assign m_err  = sel ? b_err  : a_err;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One transaction: gnt g cycles after the first request cycle, rvalid on WAIT cycle r (none if r >= timeout).
   task automatic run_op(input bit s64, input bit s, input logic [2:0] f, input logic [31:0] a,
                         input logic [63:0] wd, input logic [63:0] rd, input int g, input int r);
      int          nb, tmo, sz, off, respk, mend;
      bit          legal, mis, ld, junk;
      logic [1:0]  e, xerr;
      logic [7:0]  strb;
      logic [63:0] dm, bm, v, xdata;
      nb    = s64 ? 8 : 4;
      tmo   = s64 ? TMO64 : TMO32;
      sz    = 1 << f[1:0];
      off   = int'(a[2:0]) % nb;
      legal = s ? (f <= 3'd2 || (f == 3'd3 && s64))
                : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} || (s64 && f inside {3'd3, 3'd6}));
      mis   = (int'(a[2:0]) % sz) != 0;
      e     = !legal ? 2'd2 : mis ? 2'd1 : 2'd0;
      dm    = (sz == 8) ? '1 : (64'd1 << (8 * sz)) - 64'd1;
      strb  = 8'((16'd1 << sz) - 16'd1) << off;
      for (int i = 0; i < 8; i++) bm[8*i +: 8] = {8{strb[i]}};
      v = (rd >> (8 * off)) & dm;
      if (!f[2] && sz < 8 && v[8*sz-1]) v = v | ~dm;
      if (!s64) v = v & 64'hFFFF_FFFF;
      ld   = (e == 2'd0) && !s;
      mend = (e == 2'd0) ? 1 + g : 0;
      if (e != 2'd0) begin respk = 1; xerr = e; xdata = '0; end
      else if (s) begin respk = 2 + g; xerr = 2'd0; xdata = '0; end
      else if (r < tmo) begin respk = 3 + g + r; xerr = 2'd0; xdata = v; end
      else begin respk = 2 + g + tmo; xerr = 2'd3; xdata = '0; end
      sel = s64;
      @(posedge clk); #1;
      check("ready_idle", m_rdy, 1'b1);
      st = s; f3 = f; addr = a; wdata = wd;
      rv32 = !s64; rv64 = s64;
      for (int k = 1; k <= respk + 1; k++) begin
         @(posedge clk); #1;
         if (k <= respk) begin
            check("resp_valid", m_rv, k == respk);
            check("ready_busy", m_rdy, 1'b0);
            check("mem_req", m_req, k <= mend);
            if (k <= mend) begin
               check("mem_we", m_we, s);
               check("mem_addr", m_addr, a & ~32'(nb - 1));
               check("mem_wstrb", m_strb, strb);
               check("mem_wdata", m_wd & bm, ((wd & dm) << (8 * off)) & bm);
            end
            if (k == respk) begin
               check("resp_data", m_rd, xdata);
               check("resp_err", m_err, xerr);
            end
            junk = (k < respk);
            rv32 = !s64 && junk && ($urandom % 2 == 1);
            rv64 = s64 && junk && ($urandom % 2 == 1);
            if (junk) begin
               st = 1'($urandom); f3 = 3'($urandom); addr = $urandom; wdata = {$urandom, $urandom};
            end
            gnt = (k == mend);
            if (ld && k > mend && k < respk) begin
               rvalid = (k - mend - 1 == r);
               rdata  = rvalid ? rd : {$urandom, $urandom};
            end else begin
               rvalid = 1'($urandom);
               rdata  = {$urandom, $urandom};
            end
         end else begin
            check("ready_after", m_rdy, 1'b1);
            check("resp_after", m_rv, 1'b0);
            check("mem_req_after", m_req, 1'b0);
            rv32 = 1'b0; rv64 = 1'b0; gnt = 1'b0; rvalid = 1'b0;
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready32", a_rdy, 1'b1);
      check("rst_req32", a_req, 1'b0);
      check("rst_resp32", a_rv, 1'b0);
      check("rst_ready64", b_rdy, 1'b1);
      check("rst_req64", b_req, 1'b0);
      check("rst_resp64", b_rv, 1'b0);
      rst = 1'b1;
      run_op(0, 0, 3'd0, 32'h1003, '0, 64'h8000_0000_80FF_FF12, 0, 0);
      run_op(0, 0, 3'd4, 32'h1003, '0, 64'h8000_0000_80FF_FF12, 0, 0);
      run_op(0, 1, 3'd1, 32'h2002, 64'h0000_BEEF, '0, 2, 0);
      run_op(0, 0, 3'd2, 32'h3001, '0, '0, 0, 0);
      run_op(0, 0, 3'd3, 32'h3000, '0, '0, 0, 0);
      run_op(0, 0, 3'd2, 32'h4000, '0, 64'h1234_5678, 0, 99);
      run_op(0, 0, 3'd2, 32'h4000, '0, 64'h1234_5678, 0, TMO32 - 1);
      run_op(1, 0, 3'd3, 32'h8, '0, 64'h8000_0000_0000_0001, 0, 0);
      run_op(1, 0, 3'd2, 32'hC, '0, 64'hFFFF_FFFE_0000_0000, 0, 0);
      run_op(1, 0, 3'd6, 32'hC, '0, 64'hFFFF_FFFE_0000_0000, 0, 0);
      run_op(1, 1, 3'd3, 32'h10, 64'h0123_4567_89AB_CDEF, '0, 1, 0);
      run_op(1, 0, 3'd3, 32'h14, '0, '0, 0, 0);
      run_op(1, 0, 3'd7, 32'h0, '0, '0, 0, 0);
      run_op(1, 0, 3'd1, 32'h6, '0, 64'h8001_0000_0000_0000, 0, TMO64);
      // reset while a load sits in WAIT: abandoned with no response
      sel = 1'b0;
      @(posedge clk); #1;
      st = 1'b0; f3 = 3'd2; addr = 32'h10; rv32 = 1'b1;
      @(posedge clk); #1;
      check("mid_req", m_req, 1'b1);
      rv32 = 1'b0; gnt = 1'b1;
      @(posedge clk); #1;
      check("mid_wait_ready", m_rdy, 1'b0);
      gnt = 1'b0; rst = 1'b0;
      #1;
      check("async_ready", m_rdy, 1'b1);
      check("async_resp", m_rv, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check("post_rst_resp", m_rv, 1'b0);
         check("post_rst_ready", m_rdy, 1'b1);
      end
      for (int n = 0; n < 300; n++) begin
         logic [31:0] ra;
         ra = $urandom & 32'hFFFF;
         if ($urandom % 2 == 1) ra = ra & ~32'h7;
         run_op(1'($urandom), 1'($urandom), 3'($urandom), ra, {$urandom, $urandom},
                {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, TMO64 + 1));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
